// File: rtl/write_fifo_ptr_ctrl_if.sv
// Write-side bundle of the async FIFO pointer controller: client handshake,
// read-domain Gray pointer input, RAM write port and status flags.
interface write_fifo_ptr_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 3
);
   // Client and read-domain inputs
   logic                  w_request_in;
   logic                  w_overflow_clr_in;
   logic [ADDR_WIDTH:0]   r_ptr_gray_in;

   // RAM write port and status
   logic                  w_enable_out;
   logic [ADDR_WIDTH-1:0] w_addr_out;
   logic [ADDR_WIDTH:0]   w_ptr_gray_out;
   logic                  w_full_out;
   logic                  w_almost_full_out;
   logic [ADDR_WIDTH:0]   w_level_out;
   logic                  w_overflow_out;

   // Client / surrounding logic side
   modport master (
      output w_request_in,
      output w_overflow_clr_in,
      output r_ptr_gray_in,
      input  w_enable_out,
      input  w_addr_out,
      input  w_ptr_gray_out,
      input  w_full_out,
      input  w_almost_full_out,
      input  w_level_out,
      input  w_overflow_out
   );

   // Pointer controller side
   modport slave (
      input  w_request_in,
      input  w_overflow_clr_in,
      input  r_ptr_gray_in,
      output w_enable_out,
      output w_addr_out,
      output w_ptr_gray_out,
      output w_full_out,
      output w_almost_full_out,
      output w_level_out,
      output w_overflow_out
   );
endinterface

// File: rtl/write_fifo_ptr_ctrl.sv
// Write-domain pointer and flag controller for an asynchronous FIFO.
// Keeps a binary/Gray write pointer with a wrap bit, synchronises the read
// Gray pointer, and produces RAM write strobe/address, full, almost-full,
// a pessimistic fill level and a sticky overflow flag.
module write_fifo_ptr_ctrl #(
   parameter int unsigned ADDR_WIDTH   = 3,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned AFULL_THRESH = 6
) (
   input logic                  w_clk_in,
   input logic                  w_reset_n_in,
   write_fifo_ptr_ctrl_if.slave wr_if
);
   localparam int unsigned PW = ADDR_WIDTH + 1;
   localparam int unsigned A  = ADDR_WIDTH;

   typedef logic [PW-1:0] ptr_t;

   // Synchroniser chain; element 0 is the first flop after the domain crossing
   logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;

   ptr_t w_bin_q,   w_bin_d;
   ptr_t w_gray_q,  w_gray_d;
   ptr_t level_q,   level_d;
   logic full_q,    full_d;
   logic afull_q,   afull_d;
   logic ovf_q,     ovf_d;

   logic w_enable;
   ptr_t rptr_sync;
   ptr_t rptr_bin;
   ptr_t full_pattern;

   // Synchroniser shift: new sample enters at stage 0
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], wr_if.r_ptr_gray_in};
   end

   assign rptr_sync = sync_q[SYNC_STAGES-1];

   // Gray-to-binary of the synchronised read pointer
   always_comb begin
      rptr_bin = '0;
      for (int i = 0; i < int'(PW); i++) begin
         rptr_bin[i] = ^(rptr_sync >> i);
      end
   end

   // Write pointer equals read pointer plus DEPTH: top two Gray bits inverted
   always_comb begin
      full_pattern = rptr_sync;
      full_pattern[A]   = ~rptr_sync[A];
      full_pattern[A-1] = ~rptr_sync[A-1];
   end

   // Write acceptance: a request is dropped while full
   assign w_enable = wr_if.w_request_in & ~full_q;

   // Next-state for pointers and flags, all from the same pre-edge rptr_sync
   always_comb begin
      w_bin_d  = w_bin_q + ptr_t'(w_enable);
      w_gray_d = w_bin_d ^ (w_bin_d >> 1);
      full_d   = (w_gray_d == full_pattern);
      level_d  = w_bin_d - rptr_bin;
      afull_d  = (32'(level_d) >= AFULL_THRESH);
      // Set takes priority over clear
      ovf_d    = (wr_if.w_request_in & full_q) | (ovf_q & ~wr_if.w_overflow_clr_in);
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
      if (!w_reset_n_in) begin
         sync_q   <= '0;
         w_bin_q  <= '0;
         w_gray_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         w_bin_q  <= w_bin_d;
         w_gray_q <= w_gray_d;
         level_q  <= level_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
      end
   end

   assign wr_if.w_enable_out      = w_enable;
   assign wr_if.w_addr_out        = w_bin_q[A-1:0];
   assign wr_if.w_ptr_gray_out    = w_gray_q;
   assign wr_if.w_full_out        = full_q;
   assign wr_if.w_almost_full_out = afull_q;
   assign wr_if.w_level_out       = level_q;
   assign wr_if.w_overflow_out    = ovf_q;

endmodule

// File: tb/tb_write_fifo_ptr_ctrl.sv
// Self-checking bench for write_fifo_ptr_ctrl: directed scenarios plus
// randomized traffic against a counter-based reference model.
module tb_write_fifo_ptr_ctrl;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int SYNC  = 2;
   localparam int AF    = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   write_fifo_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   write_fifo_ptr_ctrl #(
      .ADDR_WIDTH  (AW),
      .SYNC_STAGES (SYNC),
      .AFULL_THRESH(AF)
   ) dut (
      .w_clk_in    (clk),
      .w_reset_n_in(rst_n),
      .wr_if       (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: unbounded write/read counts, read count seen by the
   // write side after a fixed edge delay, flags derived from the difference.
   int  wr_total, rd_total;
   int  rq[$];
   int  m_level;
   bit  m_full, m_afull, m_ovf;
   bit  cur_req, cur_clr;

   function automatic logic [3:0] to_gray(input int v);
      logic [3:0] b;
      b = 4'(v);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [10:0] exp_vec();
      return {to_gray(wr_total), 4'(m_level), m_full, m_afull, m_ovf};
   endfunction

   function automatic logic [10:0] obs_vec();
      return {bus.w_ptr_gray_out, bus.w_level_out, bus.w_full_out,
              bus.w_almost_full_out, bus.w_overflow_out};
   endfunction

   task automatic model_reset();
      wr_total = 0;
      rd_total = 0;
      rq = {};
      repeat (SYNC) rq.push_back(0);
      m_level = 0;
      m_full  = 1'b0;
      m_afull = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic drive(input bit req, input bit clr);
      cur_req = req;
      cur_clr = clr;
      bus.w_request_in      = req;
      bus.w_overflow_clr_in = clr;
      bus.r_ptr_gray_in     = to_gray(rd_total);
      #1;
   endtask

   task automatic clock_edge();
      int seen;
      bit en;
      en = cur_req && !m_full;
      @(posedge clk);
      seen = rq.pop_front();
      rq.push_back(rd_total);
      m_ovf = (cur_req && m_full) || (m_ovf && !cur_clr);
      if (en) wr_total++;
      m_level = ((wr_total - seen) % 16 + 16) % 16;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= AF);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      drive(1'b1, 1'b0);
      n_tests++;
      if (obs_vec() !== 11'b0 || bus.w_addr_out !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %b addr %0d, want 0 addr 0", obs_vec(), bus.w_addr_out);
      end
      n_tests++;
      if (bus.w_enable_out !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_enable: got %b, want 1", bus.w_enable_out);
      end
      drive(1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_run();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0);
         clock_edge();
      end
      n_tests++;
      if (bus.w_ptr_gray_out !== 4'b0010) begin
         n_fail++;
         $display("FAIL pre_reset_gray: got %b, want 0010", bus.w_ptr_gray_out);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      drive(1'b0, 1'b0);
      n_tests++;
      if (obs_vec() !== 11'b0 || bus.w_addr_out !== 3'd0 || bus.w_enable_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_run: got %b addr %0d en %b, want all 0",
                  obs_vec(), bus.w_addr_out, bus.w_enable_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0);
         n_tests++;
         if (bus.w_enable_out !== 1'b1 || bus.w_addr_out !== 3'(i)) begin
            n_fail++;
            $display("FAIL fill_write%0d: got en %b addr %0d, want en 1 addr %0d",
                     i, bus.w_enable_out, bus.w_addr_out, i);
         end
         clock_edge();
         n_tests++;
         if (bus.w_level_out !== 4'(i + 1) || bus.w_almost_full_out !== (i >= 5) ||
             bus.w_full_out !== (i == 7) || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fill_flags%0d: got %b, want %b", i, obs_vec(), exp_vec());
         end
      end
      n_tests++;
      if (bus.w_ptr_gray_out !== 4'b1100) begin
         n_fail++;
         $display("FAIL fill_gray: got %b, want 1100", bus.w_ptr_gray_out);
      end
   endtask

   task automatic test_overflow();
      drive(1'b1, 1'b0);
      n_tests++;
      if (bus.w_enable_out !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_enable: got %b, want 0", bus.w_enable_out);
      end
      clock_edge();
      n_tests++;
      if (bus.w_ptr_gray_out !== 4'b1100 || bus.w_overflow_out !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set: got gray %b ovf %b, want 1100 1",
                  bus.w_ptr_gray_out, bus.w_overflow_out);
      end
      drive(1'b0, 1'b0);
      clock_edge();
      n_tests++;
      if (bus.w_overflow_out !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: got %b, want 1", bus.w_overflow_out);
      end
      drive(1'b0, 1'b1);
      clock_edge();
      n_tests++;
      if (bus.w_overflow_out !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %b, want 0", bus.w_overflow_out);
      end
      drive(1'b1, 1'b1);
      clock_edge();
      n_tests++;
      if (bus.w_overflow_out !== 1'b1 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL ovf_set_wins: got %b, want %b", obs_vec(), exp_vec());
      end
      drive(1'b0, 1'b1);
      clock_edge();
      n_tests++;
      if (bus.w_overflow_out !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear2: got %b, want 0", bus.w_overflow_out);
      end
   endtask

   task automatic test_drain_release();
      rd_total = 3;
      drive(1'b0, 1'b0);
      for (int e = 1; e <= 3; e++) begin
         clock_edge();
         n_tests++;
         if (bus.w_full_out !== (e < 3) || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL drain_edge%0d: got full %b vec %b, want full %b vec %b",
                     e, bus.w_full_out, obs_vec(), (e < 3), exp_vec());
         end
      end
      n_tests++;
      if (bus.w_level_out !== 4'd5 || bus.w_almost_full_out !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_level: got level %0d afull %b, want 5 0",
                  bus.w_level_out, bus.w_almost_full_out);
      end
   endtask

   task automatic test_wrap();
      bit   en, saw_wrap, saw_full, bad_step, bad_lvl;
      logic [3:0] prev;
      int   iter;
      #2;
      rst_n = 1'b0;
      model_reset();
      drive(1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_wrap = 0; saw_full = 0; bad_step = 0; bad_lvl = 0; iter = 0;
      while (wr_total < 20 && iter < 200) begin
         iter++;
         rd_total = (wr_total > 0) ? wr_total - 1 : 0;
         drive($urandom_range(0, 3) != 0, 1'b0);
         en = cur_req && !m_full;
         if (bus.w_enable_out !== en || bus.w_addr_out !== 3'(wr_total)) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_port: got en %b addr %0d, want en %b addr %0d",
                     bus.w_enable_out, bus.w_addr_out, en, 3'(wr_total));
         end
         if (en && bus.w_addr_out === 3'd7) saw_wrap = 1;
         prev = bus.w_ptr_gray_out;
         clock_edge();
         if ($countones(prev ^ bus.w_ptr_gray_out) != (en ? 1 : 0)) bad_step = 1;
         if (bus.w_full_out === 1'b1) saw_full = 1;
         if (bus.w_level_out > 4'd4) bad_lvl = 1;
         if (obs_vec() !== exp_vec()) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_vec: got %b, want %b", obs_vec(), exp_vec());
         end
      end
      n_tests++;
      if (wr_total < 20 || !saw_wrap) begin
         n_fail++;
         $display("FAIL wrap_progress: got writes %0d wrap %b, want >=20 1", wr_total, saw_wrap);
      end
      n_tests++;
      if (bad_step) begin
         n_fail++;
         $display("FAIL wrap_gray_step: got non single-bit step, want 1-bit changes");
      end
      n_tests++;
      if (saw_full || bad_lvl) begin
         n_fail++;
         $display("FAIL wrap_no_full: got full %b level_over4 %b, want 0 0", saw_full, bad_lvl);
      end
   endtask

   task automatic test_random();
      bit en;
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         if (rd_total < wr_total && $urandom_range(0, 2) == 0) rd_total++;
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
         en = cur_req && !m_full;
         if (bus.w_enable_out !== en || bus.w_addr_out !== 3'(wr_total)) begin
            errs++;
            if (errs < 10)
               $display("FAIL rand_port%0d: got en %b addr %0d, want en %b addr %0d",
                        i, bus.w_enable_out, bus.w_addr_out, en, 3'(wr_total));
         end
         clock_edge();
         if (obs_vec() !== exp_vec()) begin
            errs++;
            if (errs < 10)
               $display("FAIL rand_vec%0d: got %b, want %b", i, obs_vec(), exp_vec());
         end
      end
      n_tests++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL rand_total: got %0d errors, want 0", errs);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_reset_mid_run();
      test_fill();
      test_overflow();
      test_drain_release();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
